// File: rtl/pio_edge_capture.sv
// -----------------------------------------------------------------------------
// pio_edge_capture
//   Parallel input port with an Avalon-MM slave register interface. It
//   synchronises the inputs, detects and latches edges, and raises an
//   interrupt from either the level or the latched edges.
//
//   Register map (word address):
//     0  data           RO   synchronised input value
//     1  reserved       RO   reads 0
//     2  interruptmask  RW   one enable bit per input
//     3  edgecapture    R/W1C latched edges, write 1 to clear
//
// Parameters
//   WIDTH        input port width, 1..32
//   EDGE_TYPE    0 rising, 1 falling, 2 any edge
//   IRQ_MODE     0 level (data & mask), 1 edge (edgecapture & mask)
//   SYNC_STAGES  synchroniser depth, 2..4
//
// Ports
//   clk         single clock for all state
//   reset       asynchronous, active-high reset
//   address     slave word address
//   chipselect  slave select, qualifies writes
//   write_n     active-low write strobe
//   writedata   write data; bits above WIDTH are ignored
//   in_port     asynchronous external inputs
//   readdata    registered read data, one cycle after address
//   irq         registered interrupt request, active-high
// -----------------------------------------------------------------------------
module pio_edge_capture #(
  parameter int WIDTH       = 1,
  parameter int EDGE_TYPE   = 0,
  parameter int IRQ_MODE    = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  // The arming counter finishes once the synchroniser and the sync_d flop
  // have both been refilled with real input samples after reset.
  localparam logic [2:0] ARM_DONE = 3'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0]                  r_sync_d;
  logic [WIDTH-1:0]                  r_mask;
  logic [WIDTH-1:0]                  r_edge_cap;
  logic [2:0]                        r_arm;

  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clear;
  logic [WIDTH-1:0] w_irq_src;
  logic [WIDTH-1:0] w_edge_cap_nxt;
  logic             w_write;
  logic             w_armed;
  logic [31:0]      w_readdata_nxt;
  logic             w_unused;

  // Upper writedata bits are don't-care when WIDTH < 32.
  assign w_unused = &{1'b0, writedata};

  assign w_sync  = r_sync[SYNC_STAGES-1];
  assign w_rise  = w_sync & ~r_sync_d;
  assign w_fall  = ~w_sync & r_sync_d;
  assign w_armed = (r_arm == ARM_DONE);
  assign w_write = chipselect & ~write_n;

  always_comb begin
    w_edge = w_rise | w_fall;
    if (EDGE_TYPE == 0) begin
      w_edge = w_rise;
    end else if (EDGE_TYPE == 1) begin
      w_edge = w_fall;
    end
  end

  assign w_clear = (w_write && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  // Clearing and a new edge on the same bit in one cycle: the edge wins.
  // While disarmed, detected edges are dropped rather than held back.
  assign w_edge_cap_nxt = (r_edge_cap & ~w_clear) | (w_armed ? w_edge : '0);

  assign w_irq_src = (IRQ_MODE == 1) ? r_edge_cap : w_sync;

  always_comb begin
    w_readdata_nxt = '0;
    case (address)
      2'd0:    w_readdata_nxt[WIDTH-1:0] = w_sync;
      2'd2:    w_readdata_nxt[WIDTH-1:0] = r_mask;
      2'd3:    w_readdata_nxt[WIDTH-1:0] = r_edge_cap;
      default: w_readdata_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync     <= '0;
      r_sync_d   <= '0;
      r_mask     <= '0;
      r_edge_cap <= '0;
      r_arm      <= '0;
      readdata   <= '0;
      irq        <= 1'b0;
    end else begin
      r_sync     <= {r_sync[SYNC_STAGES-2:0], in_port};
      r_sync_d   <= w_sync;
      r_edge_cap <= w_edge_cap_nxt;
      readdata   <= w_readdata_nxt;
      irq        <= |(w_irq_src & r_mask);
      if (!w_armed) begin
        r_arm <= r_arm + 3'd1;
      end
      if (w_write && address == 2'd2) begin
        r_mask <= writedata[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_pio_edge_capture.sv
// -----------------------------------------------------------------------------
// tb_pio_edge_capture
//   Three instances with different edge / irq / synchroniser settings share
//   one stimulus. A reference model built on the history of sampled inputs
//   predicts readdata and irq for each instance every cycle; directed steps
//   add fixed expected values at the documented boundary points.
// -----------------------------------------------------------------------------
module tb_pio_edge_capture;

  localparam int W  = 4;
  localparam int NI = 3;
  localparam int ET [NI] = '{0, 2, 1};
  localparam int IM [NI] = '{1, 0, 1};
  localparam int SS [NI] = '{2, 3, 4};

  logic          clk;
  logic          reset;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [W-1:0]  in_port;
  logic [31:0]   rd [NI];
  logic          irq_o [NI];

  int n_assert = 0;
  int n_fail   = 0;

  pio_edge_capture #(.WIDTH(W), .EDGE_TYPE(0), .IRQ_MODE(1), .SYNC_STAGES(2)) u0 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd[0]), .irq(irq_o[0]));

  pio_edge_capture #(.WIDTH(W), .EDGE_TYPE(2), .IRQ_MODE(0), .SYNC_STAGES(3)) u1 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd[1]), .irq(irq_o[1]));

  pio_edge_capture #(.WIDTH(W), .EDGE_TYPE(1), .IRQ_MODE(1), .SYNC_STAGES(4)) u2 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd[2]), .irq(irq_o[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [W-1:0] hist [$];   // hist[k] = in_port sampled at clock k+1 after reset
  int           ecnt;
  logic [W-1:0] m_mask [NI];
  logic [W-1:0] m_ecap [NI];
  logic [31:0]  m_rd   [NI];
  logic         m_irq  [NI];

  // Synchronised value seen n clocks after a sample: after k clocks since reset
  // the synchroniser output holds the sample taken at clock k-n+1 (zero before).
  function automatic logic [W-1:0] synced(int k, int n);
    int j;
    j = k - n;
    if (j < 0) return '0;
    return hist[j];
  endfunction

  task automatic model_reset();
    hist.delete();
    ecnt = 0;
    for (int i = 0; i < NI; i++) begin
      m_mask[i] = '0;
      m_ecap[i] = '0;
      m_rd[i]   = '0;
      m_irq[i]  = 1'b0;
    end
  endtask

  task automatic model_step();
    int           e;
    logic [W-1:0] cur, prev, det, clr, src;
    logic         wr;
    e  = ecnt + 1;
    wr = chipselect && !write_n;
    for (int i = 0; i < NI; i++) begin
      cur  = synced(e - 1, SS[i]);
      prev = synced(e - 2, SS[i]);
      if (ET[i] == 0)      det = cur & ~prev;
      else if (ET[i] == 1) det = ~cur & prev;
      else                 det = cur ^ prev;
      // The first SYNC_STAGES+1 clocks after reset never capture.
      if (e < SS[i] + 2) det = '0;
      clr = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
      case (address)
        2'd0:    m_rd[i] = 32'(cur);
        2'd2:    m_rd[i] = 32'(m_mask[i]);
        2'd3:    m_rd[i] = 32'(m_ecap[i]);
        default: m_rd[i] = 32'd0;
      endcase
      src       = (IM[i] == 1) ? m_ecap[i] : cur;
      m_irq[i]  = |(src & m_mask[i]);
      m_ecap[i] = (m_ecap[i] & ~clr) | det;
      if (wr && address == 2'd2) m_mask[i] = writedata[W-1:0];
    end
    hist.push_back(in_port);
    ecnt = e;
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input int idx,
                       input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[%0d]: observed %h expected %h", tag, idx, obs, exp);
    end
  endtask

  // One clock: model advances at the edge, outputs compared at the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check("model_rd", i, rd[i], m_rd[i]);
      check("model_irq", i, 32'(irq_o[i]), 32'(m_irq[i]));
    end
  endtask

  task automatic tick_n(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    logic [1:0] keep;
    keep       = address;
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = keep;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    reset      = 1'b1;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = '0;
    model_reset();

    // Reset state
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check("reset_rd", i, rd[i], 32'd0);
      check("reset_irq", i, 32'(irq_o[i]), 32'd0);
    end

    // Input held high through reset release: no capture, data visible
    in_port = 4'hF;
    @(negedge clk);
    reset = 1'b0;
    tick_n(3);
    check("data_after_3clk", 0, rd[0], 32'h0000000F);
    address = 2'd3;
    tick_n(7);
    for (int i = 0; i < NI; i++) begin
      check("no_capture_at_reset", i, rd[i], 32'd0);
      check("no_irq_at_reset", i, 32'(irq_o[i]), 32'd0);
    end

    // Rising-edge capture and edge-mode irq latency, then clear
    in_port = 4'h0;
    tick_n(8);
    bus_write(2'd2, 32'hFFFF_FFFF);
    bus_write(2'd3, 32'h0000_000F);
    tick_n(2);
    in_port = 4'h5;
    tick_n(3);
    check("ecap_rd_lag", 0, rd[0], 32'd0);
    check("irq_not_yet", 0, 32'(irq_o[0]), 32'd0);
    tick();
    check("ecap_0x5", 0, rd[0], 32'h5);
    check("irq_after_4clk", 0, 32'(irq_o[0]), 32'd1);
    tick_n(2);
    bus_write(2'd3, 32'h5);
    check("irq_still_set", 0, 32'(irq_o[0]), 32'd1);
    tick();
    check("ecap_cleared", 0, rd[0], 32'd0);
    check("irq_cleared", 0, 32'(irq_o[0]), 32'd0);

    // Edge and clear on bit 2 in the same cycle: set wins
    in_port = 4'h0;
    tick_n(8);
    bus_write(2'd3, 32'hF);
    tick_n(2);
    in_port = 4'h4;
    tick_n(2);
    bus_write(2'd3, 32'h4);
    tick();
    check("set_wins_over_clear", 0, rd[0], 32'h4);

    // Any-edge vs falling-edge instances
    in_port = 4'h0;
    tick_n(8);
    bus_write(2'd3, 32'hF);
    tick_n(2);
    in_port = 4'h1;
    tick_n(8);
    check("any_edge_rise", 1, rd[1], 32'h1);
    check("fall_ignores_rise", 2, rd[2], 32'h0);
    bus_write(2'd3, 32'hF);
    tick_n(2);
    check("any_edge_cleared", 1, rd[1], 32'h0);
    in_port = 4'h0;
    tick_n(8);
    check("any_edge_fall", 1, rd[1], 32'h1);
    check("fall_captured", 2, rd[2], 32'h1);

    // Level-mode irq on instance 1 (SYNC_STAGES=3)
    bus_write(2'd3, 32'hF);
    bus_write(2'd2, 32'h2);
    in_port = 4'h1;
    tick_n(8);
    check("level_irq_masked", 1, 32'(irq_o[1]), 32'd0);
    in_port = 4'h2;
    tick_n(3);
    check("level_irq_not_yet", 1, 32'(irq_o[1]), 32'd0);
    tick();
    check("level_irq_set", 1, 32'(irq_o[1]), 32'd1);
    address = 2'd1;
    tick();
    for (int i = 0; i < NI; i++) check("reserved_reads_0", i, rd[i], 32'd0);

    // Randomised traffic
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0) in_port = W'($urandom);
      address = 2'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        chipselect = 1'b1;
        write_n    = 1'($urandom_range(0, 1));
      end else begin
        chipselect = 1'($urandom_range(0, 1));
        write_n    = 1'b1;
      end
      writedata = $urandom;
      tick();
    end
    chipselect = 1'b0;
    write_n    = 1'b1;

    // Reset while captures are pending
    address = 2'd3;
    bus_write(2'd2, 32'hF);
    in_port = 4'h0;
    tick_n(8);
    bus_write(2'd3, 32'hF);
    tick_n(2);
    in_port = 4'hA;
    tick_n(8);
    check("pending_ecap_0xA", 0, rd[0], 32'hA);
    check("pending_irq", 0, 32'(irq_o[0]), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      check("async_reset_rd", i, rd[i], 32'd0);
      check("async_reset_irq", i, 32'(irq_o[i]), 32'd0);
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    address = 2'd2;
    tick_n(2);
    check("mask_after_reset", 0, rd[0], 32'd0);
    address = 2'd3;
    tick_n(8);
    for (int i = 0; i < NI; i++) begin
      check("ecap_after_reset", i, rd[i], 32'd0);
      check("irq_after_reset", i, 32'(irq_o[i]), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pio_edge_capture.md
PIO_EDGE_CAPTURE -- requirements
Module: pio_edge_capture

Interface
REQ-001 Parameter WIDTH, default 1, input port width, legal range 1..32.
REQ-002 Parameter EDGE_TYPE, default 0, capture edge: 0 rising, 1 falling, 2 any.
REQ-003 Parameter IRQ_MODE, default 0, irq source: 0 level (data & mask), 1 edge (edgecapture & mask).
REQ-004 Parameter SYNC_STAGES, default 2, input synchroniser depth, legal range 2..4.
REQ-005 clk  in  1  single clock for all state.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 address  in  2  Avalon-MM slave word address.
REQ-008 chipselect  in  1  slave select; qualifies writes.
REQ-009 write_n  in  1  active-low write strobe.
REQ-010 writedata  in  32  write data.
REQ-011 in_port  in  WIDTH  asynchronous external inputs.
REQ-012 readdata  out  32  registered read data.
REQ-013 irq  out  1  registered interrupt request, active-high.

Function
REQ-014 Each in_port bit SHALL pass through SYNC_STAGES flops (sync), then one further flop (sync_d) for edge detection.
REQ-015 Register map: 0 data (RO, = sync), 1 reserved (reads 0), 2 interruptmask (RW, WIDTH bits), 3 edgecapture (R, write-1-to-clear).
REQ-016 readdata SHALL update every clk from the address-selected register, zero-extended to 32 bits; read latency 1 cycle; no chipselect/read qualification.
REQ-017 Write occurs when chipselect=1 and write_n=0; writes to addresses 0 and 1 are ignored; writedata[31:WIDTH] ignored.
REQ-018 Edge detect per bit: rise = sync & ~sync_d; fall = ~sync & sync_d; selected by EDGE_TYPE.
REQ-019 A detected edge SHALL set the matching edgecapture bit on the next clk; bit stays set until cleared.
REQ-020 Write of 1 to edgecapture bit clears it next clk; write of 0 leaves it unchanged.
REQ-021 Same-cycle edge detect and clear on one bit: set wins, bit remains 1.
REQ-022 Post-reset arming counter SHALL suppress edge capture until SYNC_STAGES+1 clk edges after reset deassertion, so reset-time input levels never produce captures.
REQ-023 Arming counter saturates at SYNC_STAGES+1; edges during disarmed window are discarded, not deferred.
REQ-024 irq SHALL be registered: next-cycle value = |(source & interruptmask), source per IRQ_MODE.
REQ-025 Edge-mode irq deasserts one cycle after the last unmasked pending bit is cleared or masked.
REQ-026 Level-mode irq follows sync data; edgecapture still operates and remains readable.
REQ-027 Total latency in_port change -> edgecapture bit set: SYNC_STAGES+1 clk; -> edge-mode irq: SYNC_STAGES+2 clk.

Reset
REQ-028 reset=1 SHALL immediately clear sync chain, sync_d, interruptmask, edgecapture, arming counter, readdata and irq to 0.
REQ-029 reset asserted mid-operation SHALL discard pending captures and mask; no irq pulse on exit.
REQ-030 After reset deassertion, first register update occurs on the first rising clk.

Verification
REQ-031 WIDTH=4, EDGE_TYPE=0, IRQ_MODE=1: mask=0xF, in_port 0x0->0x5 -> edgecapture=0x5 after 3 clk, irq=1 after 4 clk; write 0x5 to addr 3 -> edgecapture=0, irq=0 next cycle.
REQ-032 in_port=0xF held through reset release -> edgecapture stays 0x0, data reads 0xF after 3 clk, irq stays 0.
REQ-033 Edge on bit 2 same cycle as write 0x4 to addr 3 -> edgecapture bit 2 reads 1.
REQ-034 EDGE_TYPE=2: bit 0 toggles 0->1->0 with clear between -> two separate captures; EDGE_TYPE=1: only the 1->0 transition captured.
REQ-035 IRQ_MODE=0, mask=0x2: in_port=0x1 -> irq 0; in_port=0x2 -> irq 1 after SYNC_STAGES+1 clk; read addr 1 -> 0x00000000.
REQ-036 reset pulse while edgecapture=0xA, mask=0xF -> all registers read 0, irq 0 within same cycle of assertion.
